// File: rtl/dfh_list_walker.sv
// dfh_list_walker: walks the DFH linked list behind one BAR, issuing CSR reads
// per node and emitting one feature record (address, type, id, GUID) per node.
`timescale 1ns/1ps
`default_nettype none

module dfh_list_walker #(
  parameter int                ADDR_W       = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                MAX_FEATURES = 32,
  parameter int                TIMEOUT_CYC  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rsp_valid,
  input  logic [63:0]       rd_rsp_data,
  output logic              feat_valid,
  input  logic              feat_ready,
  output logic [ADDR_W-1:0] feat_addr,
  output logic [3:0]        feat_type,
  output logic [11:0]       feat_id,
  output logic [127:0]      feat_guid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [5:0]        feat_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = (ADDR_W > 24) ? ADDR_W + 1 : 25;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_DFH, S_WT_DFH, S_RD_GL, S_WT_GL, S_RD_GH, S_WT_GH, S_EMIT, S_FIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [63:0]       r_dfh;
  logic [63:0]       r_gl;
  logic [63:0]       r_gh;
  logic [TW-1:0]     r_tmo;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_feat_valid;
  logic [ADDR_W-1:0] r_feat_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [5:0]        r_feat_count;

  logic [23:0]       w_nxt;
  logic [SW-1:0]     w_sum;
  logic              w_bad_link;
  logic              w_is_guid;
  logic              w_tmo_hit;
  logic [5:0]        w_cnt_inc;
  logic [22:0]       w_unused_dfh;

  // Next address is formed wide enough that any carry out of ADDR_W is visible.
  assign w_nxt        = r_dfh[39:16];
  assign w_sum        = SW'(r_cur) + SW'(w_nxt);
  assign w_bad_link   = (w_nxt == 24'd0) || (w_nxt[2:0] != 3'd0) || (|w_sum[SW-1:ADDR_W]);
  assign w_is_guid    = (rd_rsp_data[63:60] == 4'd1) || (rd_rsp_data[63:60] == 4'd4);
  assign w_tmo_hit    = (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_cnt_inc    = r_feat_count + 6'd1;
  assign w_unused_dfh = {r_dfh[59:41], r_dfh[15:12]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur        <= BASE_ADDR;
      r_dfh        <= '0;
      r_gl         <= '0;
      r_gh         <= '0;
      r_tmo        <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_feat_valid <= 1'b0;
      r_feat_addr  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'd0;
      r_feat_count <= 6'd0;
    end else begin
      r_rd_req <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
            r_feat_count <= 6'd0;
            r_cur        <= BASE_ADDR;
            r_busy       <= 1'b1;
            r_rd_req     <= 1'b1;
            r_rd_addr    <= BASE_ADDR;
            r_state      <= S_RD_DFH;
          end
        end
        S_RD_DFH: begin
          r_tmo   <= '0;
          r_gl    <= '0;
          r_gh    <= '0;
          r_state <= S_WT_DFH;
        end
        S_WT_DFH: begin
          if (rd_rsp_valid) begin
            r_dfh <= rd_rsp_data;
            if (w_is_guid) begin
              r_rd_req  <= 1'b1;
              r_rd_addr <= r_cur + ADDR_W'(8);
              r_state   <= S_RD_GL;
            end else begin
              r_feat_valid <= 1'b1;
              r_feat_addr  <= r_cur;
              r_state      <= S_EMIT;
            end
          end else if (w_tmo_hit) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd1;
            r_done     <= 1'b1;
            r_state    <= S_FIN;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_RD_GL: begin
          r_tmo   <= '0;
          r_state <= S_WT_GL;
        end
        S_WT_GL: begin
          if (rd_rsp_valid) begin
            r_gl      <= rd_rsp_data;
            r_rd_req  <= 1'b1;
            r_rd_addr <= r_cur + ADDR_W'(16);
            r_state   <= S_RD_GH;
          end else if (w_tmo_hit) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd1;
            r_done     <= 1'b1;
            r_state    <= S_FIN;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_RD_GH: begin
          r_tmo   <= '0;
          r_state <= S_WT_GH;
        end
        S_WT_GH: begin
          if (rd_rsp_valid) begin
            r_gh         <= rd_rsp_data;
            r_feat_valid <= 1'b1;
            r_feat_addr  <= r_cur;
            r_state      <= S_EMIT;
          end else if (w_tmo_hit) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd1;
            r_done     <= 1'b1;
            r_state    <= S_FIN;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_EMIT: begin
          if (feat_ready) begin
            r_feat_valid <= 1'b0;
            r_feat_count <= w_cnt_inc;
            if (r_dfh[40]) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else if (w_bad_link) begin
              r_err      <= 1'b1;
              r_err_code <= 2'd2;
              r_done     <= 1'b1;
              r_state    <= S_FIN;
            end else if (int'(w_cnt_inc) == MAX_FEATURES) begin
              r_err      <= 1'b1;
              r_err_code <= 2'd3;
              r_done     <= 1'b1;
              r_state    <= S_FIN;
            end else begin
              r_cur     <= w_sum[ADDR_W-1:0];
              r_rd_req  <= 1'b1;
              r_rd_addr <= w_sum[ADDR_W-1:0];
              r_state   <= S_RD_DFH;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_req     = r_rd_req;
  assign rd_addr    = r_rd_addr;
  assign feat_valid = r_feat_valid;
  assign feat_addr  = r_feat_addr;
  assign feat_type  = r_dfh[63:60];
  assign feat_id    = r_dfh[11:0];
  assign feat_guid  = {r_gh, r_gl};
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign feat_count = r_feat_count;

endmodule

`default_nettype wire

// File: tb/tb_dfh_list_walker.sv
// tb_dfh_list_walker: directed bench with a CSR memory responder for dfh_list_walker.
`timescale 1ns/1ps
`default_nettype none

module tb_dfh_list_walker;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst, start, rd_req, rd_rsp_valid, feat_valid, feat_ready;
  logic          busy, done, err;
  logic [AW-1:0] rd_addr, feat_addr;
  logic [63:0]   rd_rsp_data;
  logic [3:0]    feat_type;
  logic [11:0]   feat_id;
  logic [127:0]  feat_guid;
  logic [1:0]    err_code;
  logic [5:0]    feat_count;

  int checks = 0, errors = 0;
  int n_reads = 0, n_valid = 0, n_done = 0;
  int drop_addr = -1;
  int inject_req = 0, inject_ack = 0;
  bit pend = 1'b0;
  int paddr = 0;
  logic [63:0] mem [int];

  localparam logic [63:0] GL0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] GH0 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] GL2 = 64'hA5A5_0000_1111_2222;
  localparam logic [63:0] GH2 = 64'h5A5A_3333_4444_5555;

  always #5 clk = ~clk;

  dfh_list_walker #(
    .ADDR_W(AW), .BASE_ADDR(20'h0), .MAX_FEATURES(4), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_addr(feat_addr),
    .feat_type(feat_type), .feat_id(feat_id), .feat_guid(feat_guid),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .feat_count(feat_count)
  );

  // Responder: answers a request one cycle after it is seen, unless its address is dropped.
  initial begin
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      rd_rsp_valid = 1'b0;
      if (pend) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = mem.exists(paddr) ? mem[paddr] : 64'h0;
        pend = 1'b0;
      end else if (inject_req != inject_ack) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = 64'h1000_0000_1000_0FFF;
        inject_ack++;
      end
      if (rd_req) begin
        n_reads++;
        paddr = int'(rd_addr);
        pend  = (paddr != drop_addr);
      end
      if (feat_valid) n_valid++;
      if (done) n_done++;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic get_rec(input string tag, input logic [AW-1:0] a, input logic [3:0] t,
                         input logic [11:0] id, input logic [127:0] g, input int hold);
    int n = 0;
    int r0;
    while (!feat_valid && n < 200) begin
      step();
      n++;
    end
    chk({tag, " valid"}, feat_valid, 1);
    if (feat_valid) begin
      chk({tag, " addr"}, feat_addr, a);
      chk({tag, " type"}, feat_type, t);
      chk({tag, " id"}, feat_id, id);
      chk({tag, " guid"}, feat_guid, g);
      if (hold > 0) begin
        r0 = n_reads;
        for (int i = 0; i < hold; i++) step();
        chk({tag, " hold valid"}, feat_valid, 1);
        chk({tag, " hold addr"}, feat_addr, a);
        chk({tag, " hold guid"}, feat_guid, g);
        chk({tag, " hold no reads"}, n_reads - r0, 0);
      end
      feat_ready = 1'b1;
      step();
      feat_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, output int cyc);
    int n = 0;
    while (!done && n < 2000) begin
      step();
      n++;
    end
    chk({tag, " done"}, done, 1);
    cyc = n;
  endtask

  task automatic run_bad(input string tag, input logic [63:0] dfh);
    int c;
    mem.delete();
    mem[0] = dfh;
    do_start();
    chk({tag, " err cleared"}, err, 0);
    get_rec(tag, 20'h0, 4'd2, 12'h005, 128'h0, 0);
    wait_done(tag, c);
    chk({tag, " err"}, err, 1);
    chk({tag, " code"}, err_code, 2);
    chk({tag, " count"}, feat_count, 1);
    step();
  endtask

  initial begin
    int c, r0, v0, d0;
    rst = 1'b1; start = 1'b0; feat_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", {err, err_code}, 0);
    chk("reset count", feat_count, 0);
    chk("reset valid", feat_valid, 0);
    chk("reset rd_req", rd_req, 0);

    // Three-node list with backpressure on the first record.
    mem[32'h0000] = 64'h1000_0000_1000_0011;
    mem[32'h0008] = GL0;
    mem[32'h0010] = GH0;
    mem[32'h1000] = 64'h3000_0000_1000_0022;
    mem[32'h2000] = 64'h4000_0100_0000_0033;
    mem[32'h2008] = GL2;
    mem[32'h2010] = GH2;
    r0 = n_reads;
    do_start();
    chk("walk busy", busy, 1);
    get_rec("n0", 20'h0000, 4'd1, 12'h011, {GH0, GL0}, 10);
    get_rec("n1", 20'h1000, 4'd3, 12'h022, 128'h0, 0);
    get_rec("n2", 20'h2000, 4'd4, 12'h033, {GH2, GL2}, 0);
    wait_done("walk", c);
    chk("walk err", err, 0);
    chk("walk count", feat_count, 3);
    chk("walk reads", n_reads - r0, 7);
    step();
    chk("walk done pulse", done, 0);
    chk("walk idle", busy, 0);

    // GUID_H response withheld.
    mem.delete();
    mem[32'h0000] = 64'h1000_0100_0000_0044;
    drop_addr = 32'h10;
    v0 = n_valid;
    do_start();
    wait_done("tmo", c);
    chk("tmo err", err, 1);
    chk("tmo code", err_code, 1);
    chk("tmo no record", n_valid - v0, 0);
    chk("tmo count", feat_count, 0);
    chk("tmo latency", (c >= 1024 && c <= 1034), 1);
    drop_addr = -1;
    step();

    run_bad("nxt0", 64'h2000_0000_0000_0005);
    run_bad("nxt1004", 64'h2000_0000_1004_0005);
    run_bad("ovf", 64'h2000_0010_0000_0005);

    // Endless chain bounded by MAX_FEATURES=4.
    mem.delete();
    for (int i = 0; i < 6; i++) mem[i * 32'h1000] = 64'h2000_0000_1000_0007;
    r0 = n_reads;
    do_start();
    for (int i = 0; i < 4; i++)
      get_rec($sformatf("loop%0d", i), AW'(i * 32'h1000), 4'd2, 12'h007, 128'h0, 0);
    wait_done("loop", c);
    chk("loop code", err_code, 3);
    chk("loop err", err, 1);
    chk("loop count", feat_count, 4);
    chk("loop reads", n_reads - r0, 4);
    step();

    // Reset while waiting on GUID_L of the second node, then a stale response.
    mem.delete();
    mem[32'h0000] = 64'h2000_0000_1000_0001;
    mem[32'h1000] = 64'h1000_0000_1000_0002;
    drop_addr = 32'h1008;
    do_start();
    get_rec("pre", 20'h0, 4'd2, 12'h001, 128'h0, 0);
    for (int i = 0; i < 6; i++) step();
    chk("pre count", feat_count, 1);
    chk("pre busy", busy, 1);
    d0 = n_done;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst count", feat_count, 0);
    chk("rst outs", {feat_valid, rd_req, done, err, err_code}, 0);
    inject_req++;
    step(); step(); step();
    chk("stale idle", busy, 0);
    chk("stale no rd", rd_req, 0);
    drop_addr = -1;
    mem[32'h0000] = 64'h3000_0100_0000_0009;
    do_start();
    get_rec("fresh", 20'h0, 4'd3, 12'h009, 128'h0, 0);
    wait_done("fresh", c);
    chk("fresh count", feat_count, 1);
    chk("fresh err", err, 0);
    chk("rst no done", n_done - d0, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
